// File: rtl/serial_divider_pkg.sv
// Shared ALU package: divider state encoding, default width and counter sizing.
package serial_divider_pkg;

  localparam int DEFAULT_WIDTH = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  // Bits needed to count 0..w iterations.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_divider_if.sv
// Start/busy/done handshake and operand/result bus of the serial divider.
interface serial_divider_if #(
  parameter int WIDTH = serial_divider_pkg::DEFAULT_WIDTH
) ();
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/serial_divider_sub_borrow.sv
// N-bit ripple-borrow subtractor, diff = a - b with borrow-in tied to 0.
module sub_borrow #(
  parameter int N = 6
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow_out
);

  logic [N:0] w_bw;

  assign w_bw[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign diff[i]   = a[i] ^ b[i] ^ w_bw[i];
    assign w_bw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_bw[i]);
  end

  assign borrow_out = w_bw[N];

endmodule

// File: rtl/serial_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock through a
// shared (WIDTH+1)-bit subtractor, start/busy/done handshake.
module serial_divider
  import serial_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_divider_if.slave bus
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  div_state_t       r_state, w_nstate;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_r, r_q, r_d;
  logic [WIDTH-1:0] r_quot, r_rem;
  logic             r_dbz;

  logic [WIDTH:0]   w_t, w_diff;
  logic             w_borrow;
  logic [WIDTH-1:0] w_rnext, w_qnext;
  logic             w_unused_bits;

  assign w_t = {r_r, r_q[WIDTH-1]};

  sub_borrow #(.N(WIDTH + 1)) u_sub (
    .a          (w_t),
    .b          ({1'b0, r_d}),
    .diff       (w_diff),
    .borrow_out (w_borrow)
  );

  // R < D keeps T < 2D, so a non-borrowing difference never needs the top bit.
  assign w_rnext       = w_borrow ? w_t[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_qnext       = {r_q[WIDTH-2:0], ~w_borrow};
  assign w_unused_bits = ^{w_diff[WIDTH], w_t[WIDTH]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_nstate = (bus.divisor == '0) ? S_DONE : S_RUN;
      S_RUN:   if (r_cnt == LAST) w_nstate = S_DONE;
      S_DONE:  w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_r    <= '0;
      r_q    <= '0;
      r_d    <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_d   <= bus.divisor;
          r_r   <= '0;
          r_q   <= bus.dividend;
          r_cnt <= '0;
          r_dbz <= (bus.divisor == '0);
          if (bus.divisor == '0) begin
            r_quot <= '1;
            r_rem  <= bus.dividend;
          end
        end
        S_RUN: begin
          r_r   <= w_rnext;
          r_q   <= w_qnext;
          r_cnt <= r_cnt + CW'(1);
          // Results are published only on the last iteration so they hold through RUN.
          if (r_cnt == LAST) begin
            r_quot <= w_qnext;
            r_rem  <= w_rnext;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = (r_state == S_DONE);
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_serial_divider.sv
// Self-checking bench for serial_divider: vector table, corner sequences,
// exhaustive sweep and random ops against an arithmetic reference model.
module tb_serial_divider;

  localparam int W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_tot  = 0;

  always #5 clk = ~clk;

  serial_divider_if #(.WIDTH(W)) bus ();

  serial_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] a, b, q, r;
    logic         z;
    int           lat;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: plain integer arithmetic; divide by zero gives all-ones / dividend.
  task automatic model(input int a, input int b, output int q, output int r, output int z, output int lat);
    if (b == 0) begin q = (1 << W) - 1; r = a; z = 1; lat = 0; end
    else        begin q = a / b;        r = a % b; z = 0; lat = W; end
  endtask

  // Called at a negedge; returns at the negedge of the IDLE cycle after DONE.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic z, output int lat);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.dividend = W'($urandom); bus.divisor = W'($urandom);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done) begin lat = k; break; end
    end
    q = bus.quotient; r = bus.remainder; z = bus.div_by_zero;
    @(negedge clk);
    check("done_one_cycle", {bus.done, bus.busy}, 0);
  endtask

  vec_t         tv[5];
  logic [W-1:0] q, r;
  logic         z;
  int           lat, eq, er, ez, el, ndone;

  initial begin
    tv[0] = '{a: 5'd23, b: 5'd5, q: 5'd4,  r: 5'd3,  z: 1'b0, lat: W};
    tv[1] = '{a: 5'd31, b: 5'd1, q: 5'd31, r: 5'd0,  z: 1'b0, lat: W};
    tv[2] = '{a: 5'd7,  b: 5'd9, q: 5'd0,  r: 5'd7,  z: 1'b0, lat: W};
    tv[3] = '{a: 5'd31, b: 5'd0, q: 5'd31, r: 5'd31, z: 1'b1, lat: 0};
    tv[4] = '{a: 5'd0,  b: 5'd7, q: 5'd0,  r: 5'd0,  z: 1'b0, lat: W};

    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    #12;
    check("reset_outputs", {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Table vectors, issued back-to-back (each start lands in the IDLE cycle after DONE).
    for (int i = 0; i < 5; i++) begin
      do_op(tv[i].a, tv[i].b, q, r, z, lat);
      check($sformatf("tv%0d_quotient", i), q, tv[i].q);
      check($sformatf("tv%0d_remainder", i), r, tv[i].r);
      check($sformatf("tv%0d_dbz", i), z, tv[i].z);
      check($sformatf("tv%0d_latency", i), lat, tv[i].lat);
    end

    // Start during RUN must be ignored.
    bus.start = 1'b1; bus.dividend = 5'd20; bus.divisor = 5'd3;
    @(posedge clk); #1; bus.start = 1'b0;
    ndone = 0; lat = -1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k == 2) begin bus.start = 1'b1; bus.dividend = 5'd9; bus.divisor = 5'd9; end
      else bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        if (lat < 0) begin lat = k; q = bus.quotient; r = bus.remainder; end
      end
    end
    bus.start = 1'b0;
    check("ignored_start_quotient", q, 6);
    check("ignored_start_remainder", r, 2);
    check("ignored_start_done_count", ndone, 1);
    check("ignored_start_latency", lat, W);

    // Reset mid-RUN aborts with no done pulse.
    bus.start = 1'b1; bus.dividend = 5'd17; bus.divisor = 5'd4;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0; #1;
    check("abort_outputs", {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero}, 0);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin @(negedge clk); if (bus.done) ndone++; end
    check("abort_no_done", ndone, 0);
    do_op(5'd17, 5'd4, q, r, z, lat);
    check("after_abort_result", {q, r, z}, {5'd4, 5'd1, 1'b0});

    // Exhaustive sweep over non-zero divisors.
    for (int a = 0; a < (1 << W); a++)
      for (int b = 1; b < (1 << W); b++) begin
        do_op(W'(a), W'(b), q, r, z, lat);
        model(a, b, eq, er, ez, el);
        check($sformatf("sweep_%0d_%0d", a, b), {q, r, z, 8'(lat)}, {W'(eq), W'(er), 1'(ez), 8'(el)});
      end

    // Random operands, divide-by-zero included.
    for (int i = 0; i < 60; i++) begin
      int a, b;
      a = int'($urandom_range((1 << W) - 1));
      b = ($urandom_range(7) == 0) ? 0 : int'($urandom_range((1 << W) - 1));
      do_op(W'(a), W'(b), q, r, z, lat);
      model(a, b, eq, er, ez, el);
      check($sformatf("rand_%0d_%0d", a, b), {q, r, z, 8'(lat)}, {W'(eq), W'(er), 1'(ez), 8'(el)});
      if ($urandom_range(1) == 1) repeat ($urandom_range(3)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
